// File: rtl/core_pkg.sv
// Shared widths, address map, stage FSM states and writeback payload for the core.
package core_pkg;

    localparam int unsigned DATA_W      = 32;
    localparam int unsigned REG_ADDR_W  = 4;
    localparam int unsigned SRAM_ADDR_W = 16;
    localparam int unsigned MEM_BASE    = 1024;

    typedef enum logic {
        ST_IDLE,
        ST_WAIT
    } state_t;

    // Writeback triple driving the register file write port.
    typedef struct packed {
        logic                  en;
        logic [REG_ADDR_W-1:0] dest;
        logic [DATA_W-1:0]     value;
    } wb_t;

    // Byte address to SRAM word index; addresses below MEM_BASE wrap modulo 2^DATA_W.
    function automatic logic [SRAM_ADDR_W-1:0] word_addr(input logic [DATA_W-1:0] byte_addr);
        logic [DATA_W-1:0] offset;
        offset = byte_addr - DATA_W'(MEM_BASE);
        return SRAM_ADDR_W'(offset >> 2);
    endfunction

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register; holds while the pipeline is frozen.
module mem_wb_reg
    import core_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic freeze,
    input  wb_t  d,
    output wb_t  q
);

    // Load on every unfrozen edge, clear on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (!freeze) begin
            q <= d;
        end
    end

endmodule

// File: rtl/mem_wb_stage.sv
// Memory-access stage: LDR/STR over a req/ack SRAM port, upstream freeze, MEM/WB register.
module mem_wb_stage
    import core_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DATA_W-1:0]      in_alu_result,
    input  logic [DATA_W-1:0]      in_store_val,
    input  logic [REG_ADDR_W-1:0]  in_dest,
    input  logic                   in_wb_en,
    input  logic                   in_mem_r_en,
    input  logic                   in_mem_w_en,
    output logic                   freeze,
    output logic                   sram_req,
    output logic                   sram_we,
    output logic [SRAM_ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0]      sram_wdata,
    input  logic                   sram_ack,
    input  logic [DATA_W-1:0]      sram_rdata,
    output logic                   wb_en,
    output logic [REG_ADDR_W-1:0]  wb_dest,
    output logic [DATA_W-1:0]      wb_value
);

    state_t                 state, state_n;
    logic                   req_n, we_n;
    logic [SRAM_ADDR_W-1:0] addr_n;
    logic [DATA_W-1:0]      wdata_n;
    wb_t                    wb_d, wb_q;

    // State and SRAM request registers; reset abandons any outstanding access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            sram_req   <= 1'b0;
            sram_we    <= 1'b0;
            sram_addr  <= '0;
            sram_wdata <= '0;
        end else begin
            state      <= state_n;
            sram_req   <= req_n;
            sram_we    <= we_n;
            sram_addr  <= addr_n;
            sram_wdata <= wdata_n;
        end
    end

    // Next state, request capture and the combinational freeze.
    always_comb begin
        state_n = state;
        req_n   = sram_req;
        we_n    = sram_we;
        addr_n  = sram_addr;
        wdata_n = sram_wdata;
        freeze  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (in_mem_r_en || in_mem_w_en) begin
                    freeze  = 1'b1;
                    state_n = ST_WAIT;
                    req_n   = 1'b1;
                    we_n    = in_mem_w_en;
                    addr_n  = word_addr(in_alu_result);
                    wdata_n = in_store_val;
                end
            end
            ST_WAIT: begin
                freeze = ~sram_ack;
                if (sram_ack) begin
                    state_n = ST_IDLE;
                    req_n   = 1'b0;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
        // Pipeline must not be held while the core is in reset.
        if (rst) begin
            freeze = 1'b0;
        end
    end

    // Loads take the SRAM read data, everything else forwards the EX result.
    always_comb begin
        wb_d.en    = in_wb_en;
        wb_d.dest  = in_dest;
        wb_d.value = in_mem_r_en ? sram_rdata : in_alu_result;
    end

    mem_wb_reg u_wb_reg (
        .clk    (clk),
        .rst    (rst),
        .freeze (freeze),
        .d      (wb_d),
        .q      (wb_q)
    );

    assign wb_en    = wb_q.en;
    assign wb_dest  = wb_q.dest;
    assign wb_value = wb_q.value;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage with a behavioural SRAM and pipeline model.
module tb_mem_wb_stage;
    import core_pkg::*;

    logic        clk;
    logic        rst;
    logic [31:0] in_alu_result;
    logic [31:0] in_store_val;
    logic [3:0]  in_dest;
    logic        in_wb_en;
    logic        in_mem_r_en;
    logic        in_mem_w_en;
    logic        freeze;
    logic        sram_req;
    logic        sram_we;
    logic [15:0] sram_addr;
    logic [31:0] sram_wdata;
    logic        sram_ack;
    logic [31:0] sram_rdata;
    logic        wb_en;
    logic [3:0]  wb_dest;
    logic [31:0] wb_value;

    int checks;
    int errors;
    logic [31:0] mem_model [int];

    mem_wb_stage dut (
        .clk           (clk),
        .rst           (rst),
        .in_alu_result (in_alu_result),
        .in_store_val  (in_store_val),
        .in_dest       (in_dest),
        .in_wb_en      (in_wb_en),
        .in_mem_r_en   (in_mem_r_en),
        .in_mem_w_en   (in_mem_w_en),
        .freeze        (freeze),
        .sram_req      (sram_req),
        .sram_we       (sram_we),
        .sram_addr     (sram_addr),
        .sram_wdata    (sram_wdata),
        .sram_ack      (sram_ack),
        .sram_rdata    (sram_rdata),
        .wb_en         (wb_en),
        .wb_dest       (wb_dest),
        .wb_value      (wb_value)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM contents: unwritten words return a recognisable address-derived pattern.
    function automatic logic [31:0] sram_peek(input int a);
        if (mem_model.exists(a)) return mem_model[a];
        return {16'hA5A5, 16'(a)};
    endfunction

    // Issue one instruction (called at posedge+1) and check it cycle by cycle.
    // d = request cycles before the ack cycle; spur = ack pulse in the issue cycle.
    task automatic execute(input string tag, input logic [31:0] alu, input logic [31:0] store,
                           input logic [3:0] dest, input logic wb, input logic r, input logic w,
                           input int d, input logic spur);
        logic        mem;
        logic [31:0] diff;
        int          exp_addr;
        logic [31:0] exp_val;
        int          nfz;
        int          acks;
        mem      = r | w;
        diff     = alu - 32'd1024;
        exp_addr = int'((diff / 32'd4) % 32'd65536);
        exp_val  = r ? sram_peek(exp_addr) : alu;
        nfz      = mem ? d + 1 : 0;
        acks     = 0;
        in_alu_result = alu;
        in_store_val  = store;
        in_dest       = dest;
        in_wb_en      = wb;
        in_mem_r_en   = r;
        in_mem_w_en   = w;
        for (int c = 0; c <= nfz; c++) begin
            sram_ack   = (mem && c == d + 1) || (spur && c == 0);
            sram_rdata = sram_peek(int'(sram_addr));
            @(negedge clk);
            checks++;
            if (freeze !== (c < nfz)) begin
                errors++;
                $display("FAIL %s freeze cycle %0d: got %b expected %b", tag, c, freeze, (c < nfz));
            end
            if (mem && c >= 1) begin
                checks++;
                if (sram_req !== 1'b1 || sram_we !== w || int'(sram_addr) != exp_addr) begin
                    errors++;
                    $display("FAIL %s request cycle %0d: got req=%b we=%b addr=%0h expected req=1 we=%b addr=%0h",
                             tag, c, sram_req, sram_we, sram_addr, w, exp_addr);
                end
                if (w) begin
                    checks++;
                    if (sram_wdata !== store) begin
                        errors++;
                        $display("FAIL %s wdata cycle %0d: got %h expected %h", tag, c, sram_wdata, store);
                    end
                end
            end
            if (sram_req === 1'b1 && sram_ack === 1'b1) acks++;
            @(posedge clk);
            #1;
        end
        sram_ack = 1'b0;
        if (mem) begin
            checks++;
            if (acks != 1) begin
                errors++;
                $display("FAIL %s access count: got %0d expected 1", tag, acks);
            end
            checks++;
            if (sram_req !== 1'b0) begin
                errors++;
                $display("FAIL %s req after ack: got %b expected 0", tag, sram_req);
            end
        end
        checks++;
        if (wb_en !== wb || wb_dest !== dest || wb_value !== exp_val) begin
            errors++;
            $display("FAIL %s writeback: got en=%b dest=%0d value=%h expected en=%b dest=%0d value=%h",
                     tag, wb_en, wb_dest, wb_value, wb, dest, exp_val);
        end
        if (w) mem_model[exp_addr] = store;
        in_mem_r_en = 1'b0;
        in_mem_w_en = 1'b0;
    endtask

    task automatic test_reset();
        rst           = 1'b1;
        in_alu_result = 32'd1028;
        in_store_val  = 32'hFFFF_FFFF;
        in_dest       = 4'd9;
        in_wb_en      = 1'b1;
        in_mem_r_en   = 1'b1;
        in_mem_w_en   = 1'b0;
        sram_ack      = 1'b0;
        sram_rdata    = 32'h0;
        repeat (2) @(posedge clk);
        #2;
        checks++;
        if (sram_req !== 1'b0 || sram_we !== 1'b0 || sram_addr !== 16'h0 || sram_wdata !== 32'h0) begin
            errors++;
            $display("FAIL reset sram: got req=%b we=%b addr=%h wdata=%h expected all 0",
                     sram_req, sram_we, sram_addr, sram_wdata);
        end
        checks++;
        if (wb_en !== 1'b0 || wb_dest !== 4'd0 || wb_value !== 32'h0) begin
            errors++;
            $display("FAIL reset wb: got en=%b dest=%0d value=%h expected all 0", wb_en, wb_dest, wb_value);
        end
        checks++;
        if (freeze !== 1'b0) begin
            errors++;
            $display("FAIL reset freeze: got %b expected 0", freeze);
        end
        in_mem_r_en = 1'b0;
        in_wb_en    = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_add();
        execute("add", 32'h0000_00AA, 32'h0, 4'd3, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    endtask

    task automatic test_ldr();
        mem_model[1] = 32'hDEAD_BEEF;
        execute("ldr", 32'd1028, 32'h0, 4'd5, 1'b1, 1'b1, 1'b0, 2, 1'b0);
    endtask

    task automatic test_str();
        execute("str", 32'd1036, 32'h1234_5678, 4'd2, 1'b0, 1'b0, 1'b1, 1, 1'b0);
    endtask

    task automatic test_back_to_back();
        execute("b2b_ldr", 32'd1040, 32'h0, 4'd7, 1'b1, 1'b1, 1'b0, 1, 1'b0);
        execute("b2b_str", 32'd1044, 32'hCAFE_0001, 4'd8, 1'b0, 1'b0, 1'b1, 1, 1'b0);
        execute("b2b_readback", 32'd1044, 32'h0, 4'd9, 1'b1, 1'b1, 1'b0, 0, 1'b0);
    endtask

    task automatic test_reset_mid();
        execute("pre_add", 32'h55, 32'h0, 4'd1, 1'b1, 1'b0, 1'b0, 0, 1'b0);
        in_alu_result = 32'd1028;
        in_dest       = 4'd4;
        in_wb_en      = 1'b1;
        in_mem_r_en   = 1'b1;
        sram_ack      = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (sram_req !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid request: got %b expected 1", sram_req);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (sram_req !== 1'b0 || wb_en !== 1'b0 || freeze !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid abandon: got req=%b wb_en=%b freeze=%b expected 0 0 0",
                     sram_req, wb_en, freeze);
        end
        in_mem_r_en = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        execute("post_rst_add", 32'h0000_0123, 32'h0, 4'd6, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    endtask

    task automatic test_spurious_ack();
        mem_model[0] = 32'h0BAD_F00D;
        execute("spurious_ldr0", 32'd1024, 32'h0, 4'd10, 1'b1, 1'b1, 1'b0, 1, 1'b1);
    endtask

    task automatic test_random();
        logic [31:0] alu;
        logic [1:0]  kind;
        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 7) == 0) alu = $urandom();
            else alu = 32'd1024 + 32'($urandom_range(0, 15)) * 32'd4 + 32'($urandom_range(0, 3));
            kind = 2'($urandom_range(0, 3));
            execute("random", alu, $urandom(), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                    kind[0], kind[1], int'($urandom_range(0, 3)), 1'b0);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_add();
        test_ldr();
        test_str();
        test_back_to_back();
        test_reset_mid();
        test_spurious_ack();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Memory-access stage plus MEM/WB pipeline register of the 32-bit ARM-style core.
- Takes the EX/MEM bundle and performs LDR/STR through a multi-cycle req/ack SRAM port.
- Freezes the upstream pipeline while a memory access is outstanding.
- Produces the registered writeback triple (wb_en, wb_dest, wb_value) that drives the register file write port.
- The register file commits on the following negedge.

Parameters:
- DATA_W, 32, datapath and SRAM data width
- REG_ADDR_W, 4, register index width
- SRAM_ADDR_W, 16, SRAM word-address width
- MEM_BASE, 1024, byte address that maps to SRAM word 0

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_alu_result  in  DATA_W  EX result; the byte address for memory ops
- in_store_val  in  DATA_W  STR data (Rm value from the register file)
- in_dest  in  REG_ADDR_W  destination register
- in_wb_en  in  1  instruction writes a register
- in_mem_r_en  in  1  LDR
- in_mem_w_en  in  1  STR
- freeze  out  1  hold PC and all upstream pipeline registers
- sram_req  out  1  access request, held until ack
- sram_we  out  1  1 = write, 0 = read
- sram_addr  out  SRAM_ADDR_W  word address
- sram_wdata  out  DATA_W  write data
- sram_ack  in  1  access complete; rdata valid this cycle for reads
- sram_rdata  in  DATA_W  read data
- wb_en  out  1  registered write enable to the register file
- wb_dest  out  REG_ADDR_W  registered destination
- wb_value  out  DATA_W  registered writeback data

Behaviour:

Reset:
- rst asserts asynchronously and forces state IDLE.
- sram_req, sram_we, wb_en all go to 0.
- wb_dest = 0, wb_value = 0.
- sram_addr and sram_wdata = 0.
- freeze is combinational and therefore 0 while in reset.

Address and data:
- sram_addr = ((in_alu_result - MEM_BASE) >> 2), truncated to SRAM_ADDR_W bits.
- Subtraction is modulo 2^DATA_W; addresses below MEM_BASE wrap silently.
- Byte offset bits [1:0] are ignored (word access only).

FSM (2 states):
- IDLE:
  - No memory op: sram_req = 0 and freeze = 0.
  - If in_mem_r_en or in_mem_w_en: capture sram_addr, sram_wdata = in_store_val, sram_we = in_mem_w_en; set sram_req = 1 on the next edge; go to WAIT.
  - freeze = 1 combinationally in the same cycle the memory op is seen.
  - If both enables are set: treat as a write (sram_we = 1); in_wb_en is still honoured.
- WAIT:
  - sram_req held at 1; sram_addr, sram_we and sram_wdata held stable.
  - freeze = ~sram_ack.
  - On sram_ack: sram_req drops at the next edge and the state returns to IDLE.
  - sram_ack seen in IDLE is ignored.

Freeze equation:
- freeze = (IDLE & (in_mem_r_en | in_mem_w_en)) | (WAIT & ~sram_ack).

WB register:
- Loads on every rising edge where freeze = 0; otherwise holds its value.
- wb_en = in_wb_en; wb_dest = in_dest.
- wb_value = sram_rdata if in_mem_r_en, else in_alu_result.

Latency and throughput:
- Non-memory instruction: 1 cycle, no stall.
- Memory op: 1 + N cycles, where N = cycles from sram_req assertion to sram_ack (minimum 1).
- Back-to-back memory ops: WAIT → IDLE → new request with no dead cycle beyond the IDLE issue cycle.

Upstream contract:
- The upstream bundle must stay constant while freeze = 1.
- Do not register the upstream bundle inside this block.

Reset mid-access:
- Abandons the access: sram_req drops and the WB register clears.
- The SRAM controller must tolerate a dropped request.

Decomposition:
- Shared package core_pkg holds: DATA_W, REG_ADDR_W, MEM_BASE, and the state enum {ST_IDLE, ST_WAIT}.
- Optional sub-module mem_wb_reg: the freeze-gated pipeline register. The rest stays in one module.

Test Plan:
1. ADD result 32'h0000_00AA, dest 3, wb_en 1, no mem op → freeze stays 0; next edge wb_en = 1, wb_dest = 3, wb_value = 32'hAA.
2. LDR addr 1028, dest 5, SRAM acks 2 cycles after req with rdata 32'hDEAD_BEEF:
   - sram_addr = 1, sram_we = 0.
   - freeze high for 3 cycles.
   - wb_value = 32'hDEADBEEF, wb_dest = 5, loaded on the ack edge.
3. STR addr 1036, value 32'h1234_5678, ack after 1 cycle → sram_we = 1, sram_addr = 3, sram_wdata = 32'h12345678; wb_en = 0 after completion.
4. LDR then immediate STR, each acked after 1 cycle → two distinct requests, addresses held stable through each WAIT, no lost or duplicated access.
5. Assert rst during WAIT of an LDR → sram_req, wb_en and freeze are 0 within the same cycle; after release, state is IDLE and a fresh ADD completes normally.
6. Spurious sram_ack pulse in IDLE plus an LDR at address 1024 (word 0) → ack ignored, request issued to word 0, completes on the genuine ack.
